// File: rtl/vga_stream_pkg.sv
// Shared types and constants for the VGA grayscale receive path.
// FSM states, sideband bundle, luma weights and product helper.
package vga_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VIDEO = 2'd1,
        DROP  = 2'd2
    } state_t;

    typedef struct packed {
        logic sop;
        logic eop;
        logic hdr;
    } side_t;

    localparam logic [3:0] PKT_VIDEO = 4'h0;

    localparam int KR         = 77;
    localparam int KG         = 150;
    localparam int KB         = 29;
    localparam int LUMA_SHIFT = 10;

    // 1023*150 needs 18 bits; the three-way sum still fits in 18.
    localparam int PROD_W = 18;

    function automatic logic [PROD_W-1:0] weigh(
        input logic [9:0] c,
        input int         k
    );
        return PROD_W'(c) * PROD_W'(k);
    endfunction

endpackage

// File: rtl/rgb_luma_pipe.sv
// Two-stage elastic RGB-to-luma pipeline with sop/eop/hdr sideband.
// Stage 1 holds weighted products, stage 2 holds the 8-bit luma.
module rgb_luma_pipe
    import vga_stream_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [29:0] rgb,
    input  side_t       side_in,
    output logic        in_ready,
    output logic [7:0]  y,
    output logic        y_valid,
    output logic        y_sop,
    output logic        y_eop,
    input  logic        y_ready
);

    logic              s1_valid;
    side_t             s1_side;
    logic [PROD_W-1:0] pr;
    logic [PROD_W-1:0] pg;
    logic [PROD_W-1:0] pb;

    logic              s2_valid;
    side_t             s2_side;
    logic [7:0]        s2_y;

    logic              advance;
    logic [PROD_W-1:0] sum;

    assign advance  = !s2_valid || y_ready;
    assign in_ready = !s1_valid || advance;
    assign sum      = pr + pg + pb;

    // Stage 1: capture per-channel products when the slot is free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_side  <= '0;
            pr       <= '0;
            pg       <= '0;
            pb       <= '0;
        end else if (in_ready) begin
            s1_valid <= push;
            if (push) begin
                s1_side <= side_in;
                pr      <= weigh(rgb[29:20], KR);
                pg      <= weigh(rgb[19:10], KG);
                pb      <= weigh(rgb[9:0], KB);
            end
        end
    end

    // Stage 2: sum and scale; header beats bypass luma as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_side  <= '0;
            s2_y     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_side <= s1_side;
                s2_y    <= s1_side.hdr ? 8'h00
                                       : sum[PROD_W-1:LUMA_SHIFT];
            end
        end
    end

    assign y       = s2_valid ? s2_y : 8'h00;
    assign y_valid = s2_valid;
    assign y_sop   = s2_valid && s2_side.sop;
    assign y_eop   = s2_valid && s2_side.eop;

endmodule

// File: rtl/vga_gray_producer.sv
// Packet filter and framer for the VGA grayscale receive path.
// Optional frame length check enabled by macro FRAME_CHECK_EN.
module vga_gray_producer
    import vga_stream_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CNT_W  = 19
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] data,
    input  logic        startofpacket,
    input  logic        endofpacket,
    input  logic        valid,
    output logic        ready,
    output logic [7:0]  pixel_out,
    output logic        valid_out,
    output logic        startofpacket_out,
    output logic        endofpacket_out,
    input  logic        ready_in,
    output logic        frame_error
);

    state_t state;
    state_t nxt;
    logic   acc;
    logic   push;
    side_t  side;

`ifdef FRAME_CHECK_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH * HEIGHT - 1);

    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             err;
`endif

    assign acc = valid && ready;

    // Decode each accepted beat into next state and pipeline push.
    always_comb begin
        nxt  = state;
        push = 1'b0;
        side = '0;
`ifdef FRAME_CHECK_EN
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        err     = 1'b0;
`endif
        if (acc) begin
            if (startofpacket) begin
`ifdef FRAME_CHECK_EN
                err     = (state != IDLE);
                cnt_clr = 1'b1;
`endif
                if (data[3:0] == PKT_VIDEO) begin
                    push     = 1'b1;
                    side.sop = 1'b1;
                    side.eop = endofpacket;
                    side.hdr = 1'b1;
                    nxt      = endofpacket ? IDLE : VIDEO;
                end else begin
                    nxt = endofpacket ? IDLE : DROP;
                end
            end else begin
                unique case (state)
                    VIDEO: begin
                        push     = 1'b1;
                        side.eop = endofpacket;
                        if (endofpacket)
                            nxt = IDLE;
`ifdef FRAME_CHECK_EN
                        cnt_inc = 1'b1;
                        if (endofpacket && cnt < LAST) begin
                            err = 1'b1;
                        end else if (!endofpacket && cnt == LAST) begin
                            side.eop = 1'b1;
                            err      = 1'b1;
                            nxt      = DROP;
                        end
`endif
                    end
                    DROP: begin
                        if (endofpacket)
                            nxt = IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Packet-level state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nxt;
    end

`ifdef FRAME_CHECK_EN
    // Pixel index within the current video frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (cnt_clr)
            cnt <= '0;
        else if (cnt_inc)
            cnt <= cnt + CNT_W'(1);
    end

    assign frame_error = err;
`else
    assign frame_error = 1'b0;
`endif

    rgb_luma_pipe u_pipe (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .rgb      (data),
        .side_in  (side),
        .in_ready (ready),
        .y        (pixel_out),
        .y_valid  (valid_out),
        .y_sop    (startofpacket_out),
        .y_eop    (endofpacket_out),
        .y_ready  (ready_in)
    );

endmodule

// File: tb/tb_vga_gray_producer.sv
// Scoreboard bench for vga_gray_producer at WIDTH=4, HEIGHT=2.
// Expected beats are queued on input accept, popped on output transfer.
`timescale 1ns/1ps
module tb_vga_gray_producer;

    localparam int W = 4;
    localparam int H = 2;
`ifdef FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] data = '0;
    logic        startofpacket = 1'b0;
    logic        endofpacket = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [7:0]  pixel_out;
    logic        valid_out;
    logic        startofpacket_out;
    logic        endofpacket_out;
    logic        ready_in = 1'b1;
    logic        frame_error;

    vga_gray_producer #(
        .WIDTH  (W),
        .HEIGHT (H),
        .CNT_W  (19)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .data              (data),
        .startofpacket     (startofpacket),
        .endofpacket       (endofpacket),
        .valid             (valid),
        .ready             (ready),
        .pixel_out         (pixel_out),
        .valid_out         (valid_out),
        .startofpacket_out (startofpacket_out),
        .endofpacket_out   (endofpacket_out),
        .ready_in          (ready_in),
        .frame_error       (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] beat;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_mon;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         fe_cnt = 0;
    int         fe_base = 0;
    bit         stall_en = 1'b0;
    bit         was_stall = 1'b0;
    logic [9:0] held = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] luma(input int r, input int g,
                                        input int b);
        int s;
        s = r * 77 + g * 150 + b * 29;
        return 8'(s >> 10);
    endfunction

    always @(posedge clk) cyc++;

    // Random backpressure, about one stalled cycle in five.
    always @(posedge clk) begin
        #1;
        if (stall_en)
            ready_in = ($urandom_range(0, 4) != 0);
    end

    // Output monitor: scoreboard, latency, hold and ready checks.
    always @(negedge clk) begin
        if (!reset) begin
            was_stall = 1'b0;
        end else begin
            if (frame_error)
                fe_cnt++;
            if (was_stall)
                chk("hold", {valid_out, startofpacket_out,
                             endofpacket_out, pixel_out}, {1'b1, held});
            if (!ready)
                chk("rdy_full", {valid_out, ready_in}, 2'b10);
            if (valid_out && ready_in) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 32'(valid_out), 0);
                end else begin
                    e_mon = sb.pop_front();
                    chk("beat", {startofpacket_out, endofpacket_out,
                                 pixel_out}, e_mon.beat);
                    if (e_mon.lat)
                        chk("latency", cyc - e_mon.cyc, 2);
                end
            end
            was_stall = valid_out && !ready_in;
            held = {startofpacket_out, endofpacket_out, pixel_out};
        end
    end

    task automatic put(input logic [29:0] d, input bit sop, input bit eop,
                       input bit emit, input logic [9:0] xb);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        data = d;
        startofpacket = sop;
        endofpacket = eop;
        valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = ready;
            if (acc && emit)
                sb.push_back('{xb, cyc, !stall_en});
            @(posedge clk);
            #1;
            if (!acc && ++n > 200) begin
                chk("accept_timeout", 32'(ready), 1);
                acc = 1'b1;
            end
        end
        valid = 1'b0;
        startofpacket = 1'b0;
        endofpacket = 1'b0;
    endtask

    task automatic hdr(input logic [3:0] t, input bit eop);
        put({26'b0, t}, 1'b1, eop, t == 4'h0, {1'b1, eop, 8'h00});
    endtask

    task automatic frame(input int n);
        int  r, g, b;
        bit  last, emit, forced;
        hdr(4'h0, 1'b0);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 1023);
            g = $urandom_range(0, 1023);
            b = $urandom_range(0, 1023);
            last   = (i == n - 1);
            emit   = !FC || (i < W * H);
            forced = FC && (i == W * H - 1) && !last;
            put({10'(r), 10'(g), 10'(b)}, 1'b0, last, emit,
                {1'b0, last || forced, luma(r, g, b)});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain", sb.size(), 0);
    endtask

    task automatic fe_check(input string tag, input int exp);
        chk(tag, fe_cnt - fe_base, exp);
        fe_base = fe_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {valid_out, startofpacket_out, endofpacket_out,
                        pixel_out, frame_error}, 0);
        chk("rst_ready", 32'(ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known colours with hard luma values
        hdr(4'h0, 1'b0);
        put({10'd1023, 10'd1023, 10'd1023}, 1'b0, 1'b0, 1'b1, {2'b00, 8'd255});
        put({10'd1023, 10'd0, 10'd0}, 1'b0, 1'b0, 1'b1, {2'b00, 8'd76});
        put({10'd0, 10'd1023, 10'd0}, 1'b0, 1'b0, 1'b1, {2'b00, 8'd149});
        put({10'd0, 10'd0, 10'd1023}, 1'b0, 1'b1, 1'b1, {2'b01, 8'd28});
        drain();
        fe_check("fe_colors", FC ? 1 : 0);

        // Control packet dropped, then full frame
        hdr(4'hF, 1'b0);
        put(30'h3ABCDEF1, 1'b0, 1'b0, 1'b0, '0);
        put(30'h0123456, 1'b0, 1'b1, 1'b0, '0);
        frame(W * H);
        drain();
        fe_check("fe_ctrl", 0);

        // Full frame under random backpressure
        stall_en = 1'b1;
        frame(W * H);
        drain();
        stall_en = 1'b0;
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fe_check("fe_stall", 0);

        // Short frame: eop on 5th pixel
        frame(5);
        drain();
        fe_check("fe_short", FC ? 1 : 0);

        // Long frame: 10 pixels
        frame(10);
        drain();
        fe_check("fe_long", FC ? 1 : 0);

        // New SOP abandons a frame in progress
        hdr(4'h0, 1'b0);
        put({10'd100, 10'd200, 10'd300}, 1'b0, 1'b0, 1'b1,
            {2'b00, luma(100, 200, 300)});
        put({10'd500, 10'd10, 10'd900}, 1'b0, 1'b0, 1'b1,
            {2'b00, luma(500, 10, 900)});
        frame(W * H);
        drain();
        fe_check("fe_abandon", FC ? 1 : 0);

        // Reset with both stages full
        ready_in = 1'b0;
        hdr(4'h0, 1'b0);
        put({10'd1023, 10'd1023, 10'd1023}, 1'b0, 1'b0, 1'b1,
            {2'b00, 8'd255});
        @(negedge clk);
        chk("full_stall", {ready, valid_out}, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_vout", 32'(valid_out), 0);
        chk("rst_mid_ready", 32'(ready), 1);
        sb.delete();
        ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        frame(W * H);
        drain();
        fe_check("fe_after_rst", 0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
